// File: rtl/regfile_write_queue.sv
// Write-side feeder for the register file: in-order result FIFO with an
// X31 drop filter, a registered regfile write port and two youngest-match
// forwarding lookups over pending entries plus the output stage.
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [ADDR_W-1:0]            inReg,
  input  logic [DATA_W-1:0]            inData,
  input  logic                         stall,
  output logic [ADDR_W-1:0]            writeReg,
  output logic [DATA_W-1:0]            writeData,
  output logic                         regWriteEnable,
  input  logic [ADDR_W-1:0]            queryReg1,
  output logic                         fwdHit1,
  output logic [DATA_W-1:0]            fwdData1,
  input  logic [ADDR_W-1:0]            queryReg2,
  output logic                         fwdHit2,
  output logic [DATA_W-1:0]            fwdData2,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

  logic [ADDR_W-1:0] reg_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] writeReg_q;
  logic [DATA_W-1:0] writeData_q;
  logic              regWriteEnable_q;

  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  fidx;

  assign inReady        = (count_q != CNT_W'(DEPTH));
  assign count          = count_q;
  assign empty          = (count_q == '0);
  assign writeReg       = writeReg_q;
  assign writeData      = writeData_q;
  assign regWriteEnable = regWriteEnable_q;

  // Handshake decode and pointer/occupancy next-state; X31 completes the
  // handshake but never occupies a slot.
  always_comb begin
    push    = inValid && inReady && (inReg != ZERO_REG);
    pop     = (count_q != '0) && !stall;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage; contents need no reset since occupancy gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem[tail_q]  <= inReg;
      data_mem[tail_q] <= inData;
    end
  end

  // Pointers, occupancy and the registered regfile write stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      writeReg_q       <= '0;
      writeData_q      <= '0;
      regWriteEnable_q <= 1'b0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      regWriteEnable_q <= pop;
      if (pop) begin
        writeReg_q  <= reg_mem[head_q];
        writeData_q <= data_mem[head_q];
      end
    end
  end

  // Forwarding: output stage is the oldest candidate, then FIFO entries from
  // head to tail, so each later match overrides and the youngest wins.
  always_comb begin
    fwdHit1  = 1'b0;
    fwdData1 = '0;
    fwdHit2  = 1'b0;
    fwdData2 = '0;
    fidx     = head_q;
    if (regWriteEnable_q && (writeReg_q == queryReg1)) begin
      fwdHit1  = 1'b1;
      fwdData1 = writeData_q;
    end
    if (regWriteEnable_q && (writeReg_q == queryReg2)) begin
      fwdHit2  = 1'b1;
      fwdData2 = writeData_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fidx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (reg_mem[fidx] == queryReg1) begin
          fwdHit1  = 1'b1;
          fwdData1 = data_mem[fidx];
        end
        if (reg_mem[fidx] == queryReg2) begin
          fwdHit2  = 1'b1;
          fwdData2 = data_mem[fidx];
        end
      end
    end
    if (queryReg1 == ZERO_REG) begin
      fwdHit1  = 1'b0;
      fwdData1 = '0;
    end
    if (queryReg2 == ZERO_REG) begin
      fwdHit2  = 1'b0;
      fwdData2 = '0;
    end
  end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Write-side feeder for the 32x64 register file: accepts register results from the execute/load path over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drives the regfile write port (writeReg, writeData, regWriteEnable) at no more than one write per cycle.
- Drops writes to X31, the hardwired zero register.
- Provides two forwarding lookups so the read side sees pending, not-yet-committed values.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, >= 2)
DATA_W, 64, data width
ADDR_W, 5, register index width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
inValid  input  1  producer has a result
inReady  output  1  queue can accept a result this cycle
inReg  input  ADDR_W  destination register index
inData  input  DATA_W  result value
stall  input  1  when 1, no entry is popped to the regfile this cycle
writeReg  output  ADDR_W  regfile write index (registered)
writeData  output  DATA_W  regfile write data (registered)
regWriteEnable  output  1  regfile write strobe (registered)
queryReg1  input  ADDR_W  forwarding lookup index, port 1
fwdHit1  output  1  pending write to queryReg1 exists
fwdData1  output  DATA_W  youngest pending value for queryReg1
queryReg2  input  ADDR_W  forwarding lookup index, port 2
fwdHit2  output  1  pending write to queryReg2 exists
fwdData2  output  DATA_W  youngest pending value for queryReg2
count  output  $clog2(DEPTH+1)  current FIFO occupancy
empty  output  1  count == 0

Behaviour:
- Reset (reset == 0, asynchronous, no clock needed):
  - head/tail pointers = 0, count = 0, empty = 1.
  - writeReg = 0, writeData = 0, regWriteEnable = 0.
  - fwdHit1/2 = 0 and fwdData1/2 = 0.
  - inReady = 1 once count is 0.
  - Entries in flight are discarded.
- Handshake:
  - inReady = (count != DEPTH), combinational.
  - An accept occurs on a rising edge where inValid && inReady.
  - inReady does not depend on a same-cycle pop: no pass-through when full.
- X31 filter:
  - An accept with inReg == 31 is consumed (handshake completes) but not enqueued.
  - count is unchanged and no regfile write results.
- Enqueue:
  - An accepted entry is written at the tail; tail = (tail+1) mod DEPTH.
- Pop:
  - Occurs on each rising edge where count != 0 and stall == 0.
  - The head entry loads writeReg/writeData, regWriteEnable <= 1, and head advances.
  - On an edge with no pop, regWriteEnable <= 0; writeReg/writeData hold their previous values.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Empty queue with push: the entry is stored; it pops at the next eligible edge (never the same edge).
- Latency:
  - Accept at edge N, with the queue empty and stall low.
  - regWriteEnable is high after edge N+1.
  - The regfile captures the value at edge N+2.
- Write rate: one regfile write per cycle maximum; strict FIFO order.
- Forwarding (combinational):
  - Searched set: all valid FIFO entries plus the output stage (writeReg/writeData while regWriteEnable == 1).
  - Youngest match wins: the youngest FIFO entry first, the output stage last.
  - queryRegX == 31 never hits.
  - The current-cycle inReg/inData are NOT searched.
  - No hit: fwdHitX = 0 and fwdDataX = 0.
- stall affects only popping; accepts continue until full.
- count arithmetic is exact over 0..DEPTH; pointers wrap modulo DEPTH.

Test Plan:
- Reset: drive reset=0 mid-run with 3 entries queued -> count=0, empty=1, regWriteEnable=0, fwdHit1/2=0 immediately, with no clock edge needed; after release inReady=1.
- Single write: stall=0, accept inReg=5, inData=64'hDEAD at edge 1 -> after edge 2 writeReg=5, writeData=64'hDEAD, regWriteEnable=1 for exactly one cycle, then 0; count returns to 0.
- Full/backpressure: stall=1, accept X1..X4 with data 10,20,30,40 -> count=4, inReady=0, fifth request X6=60 held. Release stall -> writes X1,X2,X3,X4 on consecutive cycles; X6 is accepted on the first edge after count<4, written last.
- Zero-register drop: accept inReg=31, inData=-14 -> inReady stays 1, count stays 0, regWriteEnable never asserts.
- Forwarding priority: stall=1, accept X7=100 then X7=200, query1=7, query2=8 -> fwdHit1=1, fwdData1=200, fwdHit2=0. Release stall and pop the first X7 -> fwdData1 is still 200.
- Simultaneous push/pop with wrap: stream 10 entries at one per cycle, stall=0 -> count never exceeds 1, regfile writes match input order, pointers wrap through DEPTH twice.
